// File: rtl/keypad_scan_ctrl.sv
// keypad_scan_ctrl: 4x4 active-low keypad scanner with per-sweep classification and sweep-level debounce.
module keypad_scan_ctrl #(
   parameter int SETTLE_CYCLES  = 1,
   parameter int DEBOUNCE_SCANS = 3,
   parameter int CNT_W          = 4
) (
   input  logic       scan_clk,
   input  logic       rst,
   input  logic [3:0] row_n,
   output logic [3:0] col_n,
   output logic [3:0] key_code,
   output logic       key_valid,
   output logic       key_held,
   output logic       multi_key
);
   typedef enum logic [1:0] {IDLE, PRESS_DB, HELD, REL_DB} state_t;
   localparam logic [CNT_W-1:0] SET_MAX = CNT_W'(SETTLE_CYCLES);
   localparam logic [CNT_W-1:0] DB_N    = CNT_W'(DEBOUNCE_SCANS);
   localparam logic [CNT_W-1:0] ONE     = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam bit               DB1     = DEBOUNCE_SCANS == 1;
   state_t state_q, state_d;
   logic [1:0] col_q, col_d, hits_q, hits_d, hits_now, first_row;
   logic [CNT_W-1:0] scnt_q, scnt_d, dcnt_q, dcnt_d, dnext;
   logic [3:0] acc_q, acc_d, cand_q, cand_d, code_q, code_d, row_hit, code_now;
   logic [2:0] n_hit, sum;
   logic valid_q, valid_d, held_q, held_d, multi_q, multi_d;
   logic sample, sweep_end, single, multi, match, accept, rel_key, last_db;
   always_ff @(posedge scan_clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         col_q   <= 2'd0;
         scnt_q  <= '0;
         dcnt_q  <= '0;
         hits_q  <= 2'd0;
         acc_q   <= 4'd0;
         cand_q  <= 4'd0;
         code_q  <= 4'd0;
         valid_q <= 1'b0;
         held_q  <= 1'b0;
         multi_q <= 1'b0;
      end else begin
         state_q <= state_d;
         col_q   <= col_d;
         scnt_q  <= scnt_d;
         dcnt_q  <= dcnt_d;
         hits_q  <= hits_d;
         acc_q   <= acc_d;
         cand_q  <= cand_d;
         code_q  <= code_d;
         valid_q <= valid_d;
         held_q  <= held_d;
         multi_q <= multi_d;
      end
   end
   always_comb begin
      sample    = scnt_q == SET_MAX;
      sweep_end = sample && col_q == 2'd3;
      row_hit   = ~row_n;
      n_hit     = 3'(row_hit[0]) + 3'(row_hit[1]) + 3'(row_hit[2]) + 3'(row_hit[3]);
      sum       = {1'b0, hits_q} + n_hit;
      hits_now  = sum > 3'd1 ? 2'd2 : sum[1:0];
      first_row = row_hit[0] ? 2'd0 : row_hit[1] ? 2'd1 : row_hit[2] ? 2'd2 : 2'd3;
      // The first hit of the sweep fixes the candidate; later hits only bump the count.
      code_now  = (hits_q == 2'd0 && n_hit != 3'd0) ? {col_q, first_row} : acc_q;
      single    = hits_now == 2'd1;
      multi     = hits_now == 2'd2;
      match     = single && code_now == cand_q;
      dnext     = dcnt_q + ONE;
      last_db   = dnext == DB_N;
      scnt_d    = sample ? '0 : scnt_q + ONE;
      col_d     = sample ? col_q + 2'd1 : col_q;
      hits_d    = sweep_end ? 2'd0 : sample ? hits_now : hits_q;
      acc_d     = sweep_end ? 4'd0 : sample ? code_now : acc_q;
      multi_d   = sweep_end ? multi : multi_q;
      state_d   = state_q;
      dcnt_d    = dcnt_q;
      cand_d    = cand_q;
      accept    = 1'b0;
      rel_key   = 1'b0;
      if (sweep_end) begin
         case (state_q)
            IDLE: if (single) begin
               cand_d  = code_now;
               dcnt_d  = DB1 ? '0 : ONE;
               state_d = DB1 ? HELD : PRESS_DB;
               accept  = DB1;
            end
            PRESS_DB: begin
               accept  = match && last_db;
               dcnt_d  = (match && !last_db) ? dnext : '0;
               state_d = !match ? IDLE : last_db ? HELD : PRESS_DB;
            end
            HELD: if (!(match || multi)) begin
               dcnt_d  = DB1 ? '0 : ONE;
               state_d = DB1 ? IDLE : REL_DB;
               rel_key = DB1;
            end
            REL_DB: begin
               rel_key = !(match || multi) && last_db;
               dcnt_d  = (!(match || multi) && !last_db) ? dnext : '0;
               state_d = (match || multi) ? HELD : last_db ? IDLE : REL_DB;
            end
         endcase
      end
      code_d  = accept ? cand_d : code_q;
      held_d  = accept ? 1'b1 : rel_key ? 1'b0 : held_q;
      valid_d = accept;
   end
   assign col_n     = ~(4'b0001 << col_q);
   assign key_code  = code_q;
   assign key_valid = valid_q;
   assign key_held  = held_q;
   assign multi_key = multi_q;
endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// tb_keypad_scan_ctrl: keypad matrix model plus accept-code scoreboard for keypad_scan_ctrl.
module tb_keypad_scan_ctrl;
   logic scan_clk = 1'b0, rst = 1'b1;
   logic [3:0] row_n, col_n, key_code;
   logic key_valid, key_held, multi_key;
   logic [15:0] km = 16'h0;
   logic [3:0] exp_q[$];
   logic prev_valid = 1'b0;
   int n_chk = 0, n_pass = 0;
   keypad_scan_ctrl #(.SETTLE_CYCLES(1), .DEBOUNCE_SCANS(3), .CNT_W(4)) dut (
      .scan_clk(scan_clk), .rst(rst), .row_n(row_n), .col_n(col_n),
      .key_code(key_code), .key_valid(key_valid), .key_held(key_held), .multi_key(multi_key)
   );
   always #5 scan_clk = ~scan_clk;
   // Pressed key at bit c*4+r shorts column c to row r.
   always_comb begin
      row_n = 4'hF;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            if (km[c*4+r] && !col_n[c]) row_n[r] = 1'b0;
   end
   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask
   always @(negedge scan_clk) begin
      if (key_valid) begin
         chk("valid_single_cycle", {15'd0, prev_valid}, 16'd0);
         if (exp_q.size() == 0) chk("spurious_valid", {15'd0, key_valid}, 16'd0);
         else chk("valid_code", {12'd0, key_code}, {12'd0, exp_q.pop_front()});
      end
      prev_valid = key_valid;
   end
   task automatic sweep(input logic [15:0] m);
      km = m;
      repeat (8) @(posedge scan_clk);
      #1;
   endtask
   task automatic held_is(input string tag, input logic h);
      chk(tag, {15'd0, key_held}, {15'd0, h});
   endtask
   initial begin
      #12;
      chk("rst_col", {12'd0, col_n}, 16'h000E);
      chk("rst_code", {12'd0, key_code}, 16'd0);
      chk("rst_flags", {13'd0, key_valid, key_held, multi_key}, 16'd0);
      @(negedge scan_clk) rst = 1'b0;
      for (int n = 1; n <= 40; n++) begin
         @(posedge scan_clk);
         #1;
         chk("idle_col", {12'd0, col_n}, {12'd0, ~(4'b0001 << ((n / 2) % 4))});
         chk("idle_flags", {13'd0, key_valid, key_held, multi_key}, 16'd0);
      end
      for (int s = 0; s < 2; s++) begin sweep(16'h0200); held_is("press9_early", 1'b0); end
      exp_q.push_back(4'd9);
      sweep(16'h0200);
      held_is("press9_held", 1'b1);
      chk("press9_code", {12'd0, key_code}, 16'd9);
      for (int s = 0; s < 2; s++) begin sweep(16'h0200); held_is("press9_hold", 1'b1); end
      for (int s = 0; s < 2; s++) begin sweep(16'h0); held_is("rel9_early", 1'b1); end
      sweep(16'h0);
      held_is("rel9_done", 1'b0);
      chk("rel9_code_kept", {12'd0, key_code}, 16'd9);
      for (int s = 0; s < 2; s++) begin
         sweep(16'h0021);
         chk("multi_flag", {15'd0, multi_key}, 16'd1);
         held_is("multi_no_hold", 1'b0);
      end
      sweep(16'h0001);
      chk("multi_clear", {15'd0, multi_key}, 16'd0);
      sweep(16'h0001);
      held_is("key0_early", 1'b0);
      exp_q.push_back(4'd0);
      sweep(16'h0001);
      held_is("key0_held", 1'b1);
      for (int s = 0; s < 3; s++) sweep(16'h0);
      held_is("key0_rel", 1'b0);
      sweep(16'h4000); sweep(16'h4000); sweep(16'h0); sweep(16'h4000); sweep(16'h4000);
      held_is("bounce_early", 1'b0);
      exp_q.push_back(4'd14);
      sweep(16'h4000);
      held_is("bounce_held", 1'b1);
      chk("bounce_code", {12'd0, key_code}, 16'd14);
      for (int s = 0; s < 3; s++) sweep(16'h0);
      held_is("bounce_rel", 1'b0);
      sweep(16'h0200);
      sweep(16'h0200);
      repeat (3) @(posedge scan_clk);
      #3 rst = 1'b1;
      #1;
      chk("arst_col", {12'd0, col_n}, 16'h000E);
      chk("arst_code", {12'd0, key_code}, 16'd0);
      chk("arst_flags", {13'd0, key_valid, key_held, multi_key}, 16'd0);
      repeat (5) @(posedge scan_clk);
      @(negedge scan_clk) rst = 1'b0;
      for (int s = 0; s < 2; s++) begin sweep(16'h0200); held_is("post_rst_early", 1'b0); end
      exp_q.push_back(4'd9);
      sweep(16'h0200);
      held_is("post_rst_held", 1'b1);
      chk("post_rst_code", {12'd0, key_code}, 16'd9);
      for (int s = 0; s < 3; s++) sweep(16'h0);
      held_is("post_rst_rel", 1'b0);
      chk("queue_empty", 16'(exp_q.size()), 16'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
